// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 1 << AW;

    typedef enum logic [0:0] {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of NREQ writeback sources onto the single register-file
// write port, plus the per-register busy scoreboard used for hazard stalls.
module regfile_wb_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = regfile_wb_arbiter_pkg::AW,
    parameter int DW    = regfile_wb_arbiter_pkg::DW,
    parameter int NREGS = regfile_wb_arbiter_pkg::NREGS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    output logic [NREGS-1:0]   busy,
    output logic               enc,
    output logic [AW-1:0]      addrc,
    output logic [DW-1:0]      datac
);

    import regfile_wb_arbiter_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            grant;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;
    assign win_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign win_data  = req_data[int'(gnt_idx)*DW +: DW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + PW'(1);
        end
    end

    // r0 writes are accepted (the requester sees ready) but never reach the port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enc   <= 1'b0;
            addrc <= '0;
            datac <= '0;
        end else if (grant) begin
            enc   <= (win_addr != AW'(REG_ZERO));
            addrc <= win_addr;
            datac <= win_data;
        end else begin
            enc   <= 1'b0;
        end
    end

    // Clear lines up with the register-file commit edge; a same-edge reserve wins
    // because it names a newer producer that is still outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (rsv_valid && rsv_addr == AW'(r))
                    busy[r] <= 1'b1;
                else if (enc && addrc == AW'(r))
                    busy[r] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               rsv_valid;
    logic [AW-1:0]      rsv_addr;
    logic [NREGS-1:0]   busy;
    logic               enc;
    logic [AW-1:0]      addrc;
    logic [DW-1:0]      datac;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy      (busy),
        .enc       (enc),
        .addrc     (addrc),
        .datac     (datac)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit        en;
        bit [4:0]  addr;
        bit [31:0] data;
        bit [31:0] busy;
    } exp_t;

    exp_t eq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;

    // Reference model state: pointer, last accepted write, outstanding-register set.
    int        m_ptr;
    bit [4:0]  m_addrc;
    bit [31:0] m_datac;
    bit [31:0] m_busy;
    int        m_commit;

    task automatic model_reset();
        m_ptr    = 0;
        m_addrc  = '0;
        m_datac  = '0;
        m_busy   = '0;
        m_commit = -1;
        eq.delete();
    endtask

    function automatic int winner(bit [1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit [4:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd7;
            2: return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Called at a negedge; drives one cycle, checks the grant, models the edge.
    task automatic cycle(input bit [1:0] v, input bit [4:0] a0, input bit [4:0] a1,
                         input bit [31:0] d0, input bit [31:0] d1,
                         input bit rv, input bit [4:0] ra);
        int       w;
        bit [1:0] exp_rdy;
        exp_t     e;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        rsv_valid = rv;
        rsv_addr  = ra;
        #1;
        w = winner(v);
        exp_rdy = (w < 0) ? 2'b00 : 2'(1 << w);
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b (valid %b)", req_ready, exp_rdy, v);
        end
        @(posedge clock);
        for (int r = 1; r < NREGS; r++) begin
            if (rv && ra == 5'(r)) m_busy[r] = 1'b1;
            else if (m_commit == r) m_busy[r] = 1'b0;
        end
        m_commit = -1;
        e.en = 1'b0;
        if (w >= 0) begin
            m_addrc = (w == 1) ? a1 : a0;
            m_datac = (w == 1) ? d1 : d0;
            m_ptr   = (w + 1) % NREQ;
            if (m_addrc != 5'd0) begin
                e.en     = 1'b1;
                m_commit = int'(m_addrc);
            end
        end
        e.addr = m_addrc;
        e.data = m_datac;
        e.busy = m_busy;
        eq.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle();
        cycle(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Monitor: compares each registered output against the scoreboard entry.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (mon_en) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: no expected entry for enc=%b addrc=%0d", enc, addrc);
                end else begin
                    mon_e = eq.pop_front();
                    checks++;
                    if (enc !== mon_e.en || addrc !== mon_e.addr || datac !== mon_e.data) begin
                        errors++;
                        $display("FAIL write_port: got enc=%b addrc=%0d datac=%h expected enc=%b addrc=%0d datac=%h",
                                 enc, addrc, datac, mon_e.en, mon_e.addr, mon_e.data);
                    end
                    checks++;
                    if (busy !== mon_e.busy) begin
                        errors++;
                        $display("FAIL busy: got %h expected %h", busy, mon_e.busy);
                    end
                end
            end
        end
    end

    initial begin
        req_valid = 2'b11;
        req_addr  = {5'd4, 5'd3};
        req_data  = {32'h2222_2222, 32'h1111_1111};
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        checks++;
        if (enc !== 1'b0 || addrc !== 5'd0 || datac !== 32'd0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got enc=%b addrc=%0d datac=%h busy=%h expected all zero",
                     enc, addrc, datac, busy);
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 01", req_ready);
        end
        @(posedge clock);
        #2;
        checks++;
        if (enc !== 1'b0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold: got enc=%b busy=%h expected 0 and 0", enc, busy);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Directed: first grant, single write, contention, scoreboard, collision, r0.
        cycle(2'b11, 5'd3, 5'd4, 32'hA0A0_0001, 32'hB0B0_0001, 1'b0, 5'd0);
        cycle(2'b10, 5'd0, 5'd5, 32'd0, 32'hDEAD_BEEF, 1'b0, 5'd0);
        idle();
        idle();
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 5'd3, 5'd4, 32'(i), 32'(100 + i), 1'b0, 5'd0);
        cycle(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7);
        idle();
        cycle(2'b01, 5'd7, 5'd0, 32'h7777_7777, 32'd0, 1'b0, 5'd0);
        idle();
        idle();
        cycle(2'b01, 5'd9, 5'd0, 32'h9999_9999, 32'd0, 1'b1, 5'd9);
        cycle(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9);
        idle();
        cycle(2'b01, 5'd0, 5'd0, 32'h0BAD_0BAD, 32'd0, 1'b0, 5'd0);
        cycle(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0);
        idle();

        for (int i = 0; i < 400; i++)
            cycle(2'($urandom_range(0, 3)), pick_addr(), pick_addr(), $urandom, $urandom,
                  1'($urandom_range(0, 1)), pick_addr());

        // Reset mid-stream with a write likely in flight.
        cycle(2'b11, 5'd12, 5'd13, 32'hC0DE_0012, 32'hC0DE_0013, 1'b1, 5'd14);
        mon_en    = 1'b0;
        req_valid = 2'b11;
        reset     = 1'b0;
        #1;
        checks++;
        if (enc !== 1'b0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL midreset: got enc=%b busy=%h expected 0 and 0", enc, busy);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 200; i++)
            cycle(2'($urandom_range(0, 3)), pick_addr(), pick_addr(), $urandom, $urandom,
                  1'($urandom_range(0, 1)), pick_addr());
        idle();
        idle();
        idle();
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
